// File: rtl/moore_seq_detector_param_pkg.sv
// Shared types, legal parameter bounds and the saturating-increment helper
// for the programmable Moore sequence detector.
package moore_seq_pkg;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        RUN  = 2'd1,
        HIT  = 2'd2
    } state_e;

    localparam int PAT_W_MIN = 2;
    localparam int PAT_W_MAX = 16;
    localparam int CNT_W_MIN = 1;
    localparam int CNT_W_MAX = 16;

    // Operates on the widest legal counter; callers truncate to their own width.
    function automatic logic [CNT_W_MAX-1:0] sat_inc(input logic [CNT_W_MAX-1:0] val,
                                                     input int unsigned width);
        logic [CNT_W_MAX-1:0] max_val;
        max_val = CNT_W_MAX'((32'd1 << width) - 32'd1);
        return (val == max_val) ? val : val + CNT_W_MAX'(1);
    endfunction

endpackage

// File: rtl/moore_seq_detector_param_if.sv
// Bit-stream, control and status bundle of the sequence detector.
// Optional pattern mask port present only when MOORE_SEQ_MASK_EN is defined.
interface moore_seq_detector_param_if #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8
);
    logic             en_i;
    logic             in_seq_i;
    logic             load_i;
    logic [PAT_W-1:0] pat_in_i;
`ifdef MOORE_SEQ_MASK_EN
    logic [PAT_W-1:0] pat_mask_in_i;
`endif
    logic             overlap_i;
    logic             clr_cnt_i;
    logic             out_seq_o;
    logic             armed_o;
    logic [CNT_W-1:0] match_cnt_o;

    modport master (
        output en_i, in_seq_i, load_i, pat_in_i,
`ifdef MOORE_SEQ_MASK_EN
        output pat_mask_in_i,
`endif
        output overlap_i, clr_cnt_i,
        input  out_seq_o, armed_o, match_cnt_o
    );

    modport slave (
        input  en_i, in_seq_i, load_i, pat_in_i,
`ifdef MOORE_SEQ_MASK_EN
        input  pat_mask_in_i,
`endif
        input  overlap_i, clr_cnt_i,
        output out_seq_o, armed_o, match_cnt_o
    );

endinterface

// File: rtl/moore_seq_detector_param_seq_sat_counter.sv
// Saturating up-counter with a synchronous clear that wins over increment.
module seq_sat_counter
    import moore_seq_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = CNT_W'(sat_inc(CNT_W_MAX'(cnt_q), CNT_W));
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/moore_seq_detector_param.sv
// Run-time programmable Moore sequence detector with overlap select and match counter.
// Define MOORE_SEQ_MASK_EN to add a per-bit don't-care mask loaded with the pattern.
module moore_seq_detector_param
    import moore_seq_pkg::*;
#(
    parameter int               PAT_W    = 4,
    parameter logic [PAT_W-1:0] PAT_INIT = PAT_W'(4'b1011),
    parameter int               CNT_W    = 8
) (
    input logic                       clk,
    input logic                       reset,
    moore_seq_detector_param_if.slave bus
);

    localparam int                FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    if (PAT_W < PAT_W_MIN || PAT_W > PAT_W_MAX ||
        CNT_W < CNT_W_MIN || CNT_W > CNT_W_MAX) begin : g_param_check
        $error("moore_seq_detector_param: PAT_W or CNT_W outside legal range");
    end

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    state_e            state_q, state_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              cmp_ok;
    logic              hit;

`ifdef MOORE_SEQ_MASK_EN
    logic [PAT_W-1:0] mask_q, mask_d;
    assign cmp_ok = (((hist_n ^ pat_q) & mask_q) == '0);
`else
    assign cmp_ok = (hist_n == pat_q);
`endif

    // The oldest history bit falls off the top as the new bit enters at the LSB.
    assign hist_n = PAT_W'({hist_q, bus.in_seq_i});
    assign fill_n = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);

    always_comb begin
        pat_d   = pat_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        hit     = 1'b0;
`ifdef MOORE_SEQ_MASK_EN
        mask_d  = mask_q;
`endif
        if (bus.load_i) begin
            pat_d   = bus.pat_in_i;
            hist_d  = '0;
            fill_d  = '0;
            state_d = FILL;
`ifdef MOORE_SEQ_MASK_EN
            mask_d  = bus.pat_mask_in_i;
`endif
        end else if (bus.en_i) begin
            hist_d = hist_n;
            hit    = (fill_n == FILL_FULL) && cmp_ok;
            if (hit) begin
                state_d = HIT;
            end else if (fill_n == FILL_FULL) begin
                state_d = RUN;
            end else begin
                state_d = FILL;
            end
            // Non-overlapping mode demands PAT_W fresh bits before the next match.
            fill_d = (hit && !bus.overlap_i) ? '0 : fill_n;
        end else if (state_q == HIT) begin
            state_d = RUN;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pat_q   <= PAT_INIT;
            hist_q  <= '0;
            fill_q  <= '0;
            state_q <= FILL;
`ifdef MOORE_SEQ_MASK_EN
            mask_q  <= '1;
`endif
        end else begin
            pat_q   <= pat_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            state_q <= state_d;
`ifdef MOORE_SEQ_MASK_EN
            mask_q  <= mask_d;
`endif
        end
    end

    assign bus.out_seq_o = (state_q == HIT);
    assign bus.armed_o   = (state_q != FILL);

    seq_sat_counter #(
        .CNT_W (CNT_W)
    ) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc_i (hit),
        .clr_i (bus.clr_cnt_i),
        .cnt_o (bus.match_cnt_o)
    );

endmodule

// File: tb/tb_moore_seq_detector_param.sv
// Self-checking bench: two detectors (8-bit and 2-bit counters) share one stream and
// are compared against a queue-based model, stimulus tables and hand-written sequences.
module tb_moore_seq_detector_param;

    localparam int PAT_W = 4;

    typedef struct {
        logic en;
        logic inSeq;
        logic overlap;
        logic expOut;
        logic expArmed;
        int   expCnt;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    moore_seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(8)) busA ();
    moore_seq_detector_param_if #(.PAT_W(PAT_W), .CNT_W(2)) busB ();

    assign busB.en_i      = busA.en_i;
    assign busB.in_seq_i  = busA.in_seq_i;
    assign busB.load_i    = busA.load_i;
    assign busB.pat_in_i  = busA.pat_in_i;
    assign busB.overlap_i = busA.overlap_i;
    assign busB.clr_cnt_i = busA.clr_cnt_i;
`ifdef MOORE_SEQ_MASK_EN
    assign busA.pat_mask_in_i = '1;
    assign busB.pat_mask_in_i = '1;
`endif

    moore_seq_detector_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1011), .CNT_W(8)) dutA (
        .clk   (clk),
        .reset (reset),
        .bus   (busA)
    );

    moore_seq_detector_param #(.PAT_W(PAT_W), .PAT_INIT(4'b1011), .CNT_W(2)) dutB (
        .clk   (clk),
        .reset (reset),
        .bus   (busB)
    );

    int checks = 0;
    int passed = 0;

    // Reference model: the bits accepted since the last restart, the active pattern,
    // the expected registered outputs and an unbounded count of matches.
    bit         mq[$];
    logic [3:0] mPat;
    logic       mOut;
    logic       mArmed;
    int         mCnt;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
        end
    endtask

    function automatic int satTo(input int v, input int maxVal);
        return (v > maxVal) ? maxVal : v;
    endfunction

    task automatic modelReset();
        mq.delete();
        mPat   = 4'b1011;
        mOut   = 1'b0;
        mArmed = 1'b0;
        mCnt   = 0;
    endtask

    task automatic modelStep(input logic en, input logic inBit, input logic ld,
                             input logic [3:0] patIn, input logic ovl, input logic clr);
        bit   hit;
        logic [3:0] recent;
        hit = 1'b0;
        if (ld) begin
            mPat   = patIn;
            mq.delete();
            mOut   = 1'b0;
            mArmed = 1'b0;
        end else if (en) begin
            mq.push_back(inBit);
            if (mq.size() > PAT_W) void'(mq.pop_front());
            recent = '0;
            foreach (mq[i]) recent = {recent[2:0], mq[i]};
            hit    = (mq.size() == PAT_W) && (recent == mPat);
            mOut   = hit;
            mArmed = hit || (mq.size() == PAT_W);
            if (hit && !ovl) mq.delete();
        end else begin
            mOut = 1'b0;
        end
        if (clr) mCnt = 0;
        else if (hit) mCnt++;
    endtask

    task automatic checkModel(input string tag);
        checkOutput({tag, "_out_seq"}, int'(busA.out_seq_o), int'(mOut));
        checkOutput({tag, "_armed"}, int'(busA.armed_o), int'(mArmed));
        checkOutput({tag, "_cnt8"}, int'(busA.match_cnt_o), satTo(mCnt, 255));
        checkOutput({tag, "_cnt2"}, int'(busB.match_cnt_o), satTo(mCnt, 3));
        checkOutput({tag, "_outB"}, int'(busB.out_seq_o), int'(mOut));
    endtask

    // Drives one cycle of inputs, clocks it, advances the model and compares 1 ns later.
    task automatic applyStimulus(input logic en, input logic inBit, input logic ld,
                                 input logic [3:0] patIn, input logic ovl, input logic clr);
        busA.en_i      = en;
        busA.in_seq_i  = inBit;
        busA.load_i    = ld;
        busA.pat_in_i  = patIn;
        busA.overlap_i = ovl;
        busA.clr_cnt_i = clr;
        @(posedge clk);
        modelStep(en, inBit, ld, patIn, ovl, clr);
        #1;
        checkModel("model");
    endtask

    task automatic restart(input logic [3:0] patIn, input logic ovl);
        applyStimulus(1'b0, 1'b0, 1'b1, patIn, ovl, 1'b1);
    endtask

    vec_t tbl[14];

    initial begin
        logic [6:0] stream;
        logic [6:0] outOv, armOv, outNo, armNo;
        int         cntOv[7];
        int         cntNo[7];

        stream = 7'b1011011;
        outOv  = 7'b0001001;
        armOv  = 7'b0001111;
        outNo  = 7'b0001000;
        armNo  = 7'b0001000;
        cntOv  = '{0, 0, 0, 1, 1, 1, 2};
        cntNo  = '{0, 0, 0, 1, 1, 1, 1};
        for (int i = 0; i < 7; i++) begin
            tbl[i]   = '{en: 1'b1, inSeq: stream[6-i], overlap: 1'b1,
                         expOut: outOv[6-i], expArmed: armOv[6-i], expCnt: cntOv[i]};
            tbl[i+7] = '{en: 1'b1, inSeq: stream[6-i], overlap: 1'b0,
                         expOut: outNo[6-i], expArmed: armNo[6-i], expCnt: cntNo[i]};
        end

        reset          = 1'b0;
        busA.en_i      = 1'b0;
        busA.in_seq_i  = 1'b0;
        busA.load_i    = 1'b0;
        busA.pat_in_i  = '0;
        busA.overlap_i = 1'b1;
        busA.clr_cnt_i = 1'b0;
        modelReset();
        #12;
        checkOutput("reset_out_seq", int'(busA.out_seq_o), 0);
        checkOutput("reset_armed", int'(busA.armed_o), 0);
        checkOutput("reset_cnt", int'(busA.match_cnt_o), 0);
        @(negedge clk);
        reset = 1'b1;

        // Overlapping then non-overlapping run of 1011011 against the reset pattern.
        for (int i = 0; i < 14; i++) begin
            if (i == 7) restart(4'b1011, 1'b0);
            applyStimulus(tbl[i].en, tbl[i].inSeq, 1'b0, 4'b0000, tbl[i].overlap, 1'b0);
            checkOutput($sformatf("tbl%0d_out", i), int'(busA.out_seq_o), int'(tbl[i].expOut));
            checkOutput($sformatf("tbl%0d_armed", i), int'(busA.armed_o), int'(tbl[i].expArmed));
            checkOutput($sformatf("tbl%0d_cnt", i), int'(busA.match_cnt_o), tbl[i].expCnt);
        end

        // Idle cycles between bits: same matches, each pulse one clock wide.
        restart(4'b1011, 1'b1);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b1, tbl[i].inSeq, 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("gap%0d_out", i), int'(busA.out_seq_o), int'(tbl[i].expOut));
            applyStimulus(1'b0, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
            checkOutput($sformatf("gap%0d_idle_out", i), int'(busA.out_seq_o), 0);
            checkOutput($sformatf("gap%0d_idle_armed", i), int'(busA.armed_o), int'(tbl[i].expArmed));
            checkOutput($sformatf("gap%0d_idle_cnt", i), int'(busA.match_cnt_o), tbl[i].expCnt);
        end

        // Load collides with an accepted bit: the bit is dropped, count untouched.
        restart(4'b1011, 1'b1);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1, 4'b0110, 1'b1, 1'b0);
        checkOutput("load_armed", int'(busA.armed_o), 0);
        checkOutput("load_cnt", int'(busA.match_cnt_o), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("load_pre_out", int'(busA.out_seq_o), 0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("load_hit_out", int'(busA.out_seq_o), 1);
        checkOutput("load_hit_cnt", int'(busA.match_cnt_o), 1);

        // Eight ones against 1111 give five hits; the 2-bit counter sticks at 3.
        restart(4'b1111, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("sat_cnt8", int'(busA.match_cnt_o), 5);
        checkOutput("sat_cnt2", int'(busB.match_cnt_o), 3);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1);
        checkOutput("clr_hit_out", int'(busA.out_seq_o), 1);
        checkOutput("clr_hit_cnt8", int'(busA.match_cnt_o), 0);
        checkOutput("clr_hit_cnt2", int'(busB.match_cnt_o), 0);

        // Asynchronous reset while in HIT, then the reset pattern must be back.
        restart(4'b0110, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("arst_pre_out", int'(busA.out_seq_o), 1);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("arst_out", int'(busA.out_seq_o), 0);
        checkOutput("arst_armed", int'(busA.armed_o), 0);
        checkOutput("arst_cnt", int'(busA.match_cnt_o), 0);
        modelReset();
        #1;
        reset = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b0);
        checkOutput("arst_pat_out", int'(busA.out_seq_o), 1);

        // Random traffic against the model, including loads, clears and overlap flips.
        for (int i = 0; i < 600; i++) begin
            applyStimulus(logic'($urandom_range(3) != 0), logic'($urandom_range(1)),
                          logic'($urandom_range(49) == 0), 4'($urandom),
                          logic'($urandom_range(1)), logic'($urandom_range(39) == 0));
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/moore_seq_detector_param.md
Name: moore_seq_detector_param

Overview:
Parametrised, run-time programmable Moore sequence detector for a serial bit stream. The pattern width is a parameter; the pattern and overlap mode are loaded or selected at run time. A qualified-bit enable, a saturating match counter and an armed flag are provided. It supersedes the hard-coded fixed-pattern detectors in the serial front-end.

Parameters:
PAT_W, 4, pattern length in bits (legal 2..16)
PAT_INIT, 4'b1011 (PAT_W bits), pattern value after reset
CNT_W, 8, match counter width (legal 1..16)

Ports:
clk  in  1  system clock; rising edge
reset  in  1  asynchronous, active-low reset
en  in  1  in_seq is a valid bit this cycle
in_seq  in  1  serial input bit
load  in  1  load pat_in into the pattern register; restart detection
pat_in  in  PAT_W  new pattern; MSB is compared against the oldest bit
overlap  in  1  1 = overlapping matches allowed; 0 = non-overlapping
clr_cnt  in  1  synchronous clear of match_cnt
out_seq  out  1  Moore match output; high exactly when state is HIT
armed  out  1  history full (state is RUN or HIT)
match_cnt  out  CNT_W  saturating count of matches

Behaviour:
- Reset (reset=0, asynchronous):
  - pat <= PAT_INIT, hist <= 0, fill <= 0, state <= FILL, match_cnt <= 0.
  - Outputs: out_seq=0, armed=0, match_cnt=0.
- Registers:
  - pat[PAT_W-1:0]: pattern.
  - hist[PAT_W-1:0]: history; the newest bit is the LSB.
  - fill: 0..PAT_W, saturating.
  - state: FILL / RUN / HIT.
- Accepted bit (en=1, load=0):
  - hist_n = {hist[PAT_W-2:0], in_seq}.
  - fill_n = min(fill+1, PAT_W).
  - hit = (fill_n==PAT_W) && (hist_n==pat).
- Next state:
  - hit -> HIT.
  - Otherwise fill_n==PAT_W -> RUN.
  - Otherwise -> FILL.
- Non-overlap mode (overlap=0): on a hit, fill <= 0. The following PAT_W accepted bits must all be fresh. The state is still HIT for that cycle.
- Overlap mode: fill stays at PAT_W.
- en=0: hist and fill hold. State goes HIT -> RUN, or holds if FILL/RUN. out_seq is therefore a single-cycle pulse per match.
- Outputs:
  - out_seq = (state==HIT). Registered; latency of 1 clk after the completing bit is sampled.
  - armed = (state!=FILL).
- load=1:
  - pat <= pat_in, hist <= 0, fill <= 0, state <= FILL.
  - match_cnt is unaffected.
  - load has priority over en; a bit presented in the same cycle is dropped.
- match_cnt:
  - Increments on each hit; saturates at all-ones with no wrap.
  - clr_cnt has priority over an increment in the same cycle (result 0).
- overlap is sampled per accepted bit; changing it mid-stream takes effect at the next hit.
- Reset asserted mid-operation clears everything immediately, regardless of clk.

Optional Feature:
MOORE_SEQ_MASK_EN
- Defined:
  - Adds input pat_mask_in[PAT_W-1:0], loaded into mask alongside pat on load.
  - Reset value of mask is all-ones.
  - hit uses ((hist_n ^ pat) & mask)==0; a mask bit of 0 makes that position don't-care.
- Undefined:
  - No port and no register.
  - Exact compare, hist_n==pat.

Decomposition:
- Package moore_seq_pkg:
  - State enum with FILL=2'd0, RUN=2'd1, HIT=2'd2.
  - Localparams for legal PAT_W/CNT_W bounds.
  - A function for the saturating increment.
- One sub-module, seq_sat_counter: CNT_W parameter, inc/clr inputs, clr priority, saturation. Instantiated for match_cnt.
- The history/compare logic stays in the top level.

Test Plan:
1. Reset with PAT_W=4, PAT_INIT=1011, overlap=1, en=1; stream 1,0,1,1,0,1,1 -> out_seq pulses 1 clk after bit 4 and after bit 7; match_cnt=2; armed rises after bit 4.
2. Same stream with overlap=0 -> single out_seq pulse after bit 4; match_cnt=1; fill restarts, so bits 5-7 (0,1,1) give no hit.
3. Same stream with en toggled low between every bit -> identical hits; each out_seq pulse is exactly 1 clk wide.
4. load with pat_in=0110 in the same cycle as an en=1 bit after 2 bits -> bit dropped, armed=0, match_cnt unchanged; then 0,1,1,0 -> one pulse.
5. CNT_W=2, pat=1111, overlap=1, eight 1s -> 5 hits; match_cnt saturates at 3. clr_cnt asserted with a simultaneous hit -> match_cnt=0.
6. Drive reset low asynchronously while state=HIT between clock edges -> out_seq, armed and match_cnt go to 0 immediately; pat returns to 1011.
